// File: rtl/reg_pair_writer.sv
// rtl/reg_pair_writer.sv - 16-bit register-pair op sequencer over an 8-bit register-file write port
// Reads the pair, computes LOAD/INC/DEC, then writes low byte and high byte on consecutive cycles.
module reg_pair_writer #(
  parameter bit PAIR_AF_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_op,
  input  logic [1:0]  i_req_pair,
  input  logic [15:0] i_req_data,
  output logic [2:0]  o_rd_hi_sel,
  output logic [2:0]  o_rd_lo_sel,
  input  logic [7:0]  i_rd_hi,
  input  logic [7:0]  i_rd_lo,
  output logic [2:0]  o_wr_sel,
  output logic        o_wr_en,
  output logic [7:0]  o_wr_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_result
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] PAIR_AF = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WR_LO, S_WR_HI} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q, pair_q;
  logic [15:0] data_q;
  logic [15:0] result_q, result_nxt;
  logic        skip;

  // Reserved ops and a disabled AF pair finish in CALC without touching the register file.
  assign skip = (op_q == 2'b11) || ((pair_q == PAIR_AF) && !PAIR_AF_EN);

  always_comb begin
    o_rd_hi_sel = 3'd0;
    o_rd_lo_sel = 3'd1;
    case (pair_q)
      2'b00:   begin o_rd_hi_sel = 3'd0; o_rd_lo_sel = 3'd1; end
      2'b01:   begin o_rd_hi_sel = 3'd2; o_rd_lo_sel = 3'd3; end
      2'b10:   begin o_rd_hi_sel = 3'd4; o_rd_lo_sel = 3'd5; end
      default: begin o_rd_hi_sel = 3'd7; o_rd_lo_sel = 3'd6; end
    endcase
  end

  always_comb begin
    result_nxt = data_q;
    case (op_q)
      OP_INC:  result_nxt = {i_rd_hi, i_rd_lo} + 16'd1;
      OP_DEC:  result_nxt = {i_rd_hi, i_rd_lo} - 16'd1;
      OP_LOAD: result_nxt = data_q;
      default: result_nxt = data_q;
    endcase
    // Low nibble of F is hardwired zero.
    if (pair_q == PAIR_AF) result_nxt[3:0] = 4'h0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q     <= 2'b00;
      pair_q   <= 2'b00;
      data_q   <= 16'h0000;
      result_q <= 16'h0000;
      o_result <= 16'h0000;
    end else begin
      if (state == S_IDLE && i_req_valid) begin
        op_q   <= i_req_op;
        pair_q <= i_req_pair;
        data_q <= i_req_data;
      end
      if (state == S_CALC) result_q <= result_nxt;
      if (state == S_WR_HI) o_result <= result_q;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_req_valid) state_nxt = S_CALC;
      S_CALC:  state_nxt = skip ? S_IDLE : S_WR_LO;
      S_WR_LO: state_nxt = S_WR_HI;
      S_WR_HI: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_wr_en     = 1'b0;
    o_wr_sel    = 3'd0;
    o_wr_data   = 8'h00;
    case (state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
      end
      S_CALC:  o_done = skip;
      S_WR_LO: begin
        o_wr_en   = 1'b1;
        o_wr_sel  = o_rd_lo_sel;
        o_wr_data = result_q[7:0];
      end
      S_WR_HI: begin
        o_wr_en   = 1'b1;
        o_wr_sel  = o_rd_hi_sel;
        o_wr_data = result_q[15:8];
        o_done    = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/reg_pair_writer.md
Name: reg_pair_writer

Overview:
- Sequencer between the CPU decoder/microcode and the 8-bit register file, which has a single 8-bit write port.
- Executes 16-bit register-pair operations (LD rr,nn / POP rr load, INC rr, DEC rr) by reading the pair through two register-file read ports, computing the 16-bit result and issuing two 8-bit writes: low byte, then high byte.
- Decoder issues one request per valid/ready handshake; the block reports completion with a one-cycle done pulse.

Parameters:
- PAIR_AF_EN, 1, when 1 pair code 3 maps to A/F (A = index 7, F = index 6) with F[3:0] forced to 0; when 0 pair code 3 requests complete with no writes.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, asynchronous, active-high
- i_req_valid  input  1  request valid
- o_req_ready  output  1  block can accept a request (high only in IDLE)
- i_req_op  input  2  00 LOAD, 01 INC, 10 DEC, 11 reserved (no-op)
- i_req_pair  input  2  00 BC, 01 DE, 10 HL, 11 AF
- i_req_data  input  16  LOAD value (ignored for other ops)
- o_rd_hi_sel  output  3  register-file read select, high byte of latched pair
- o_rd_lo_sel  output  3  register-file read select, low byte of latched pair
- i_rd_hi  input  8  register-file read data for o_rd_hi_sel (combinational)
- i_rd_lo  input  8  register-file read data for o_rd_lo_sel (combinational)
- o_wr_sel  output  3  register-file write select
- o_wr_en  output  1  register-file write enable
- o_wr_data  output  8  register-file write data
- o_busy  output  1  high when state is not IDLE
- o_done  output  1  one-cycle pulse in the cycle the high byte is written
- o_result  output  16  last completed 16-bit result, held until the next completion

Behaviour:
- Index map: B=0, C=1, D=2, E=3, H=4, L=5, F=6, A=7. Pair {hi,lo}: BC={0,1}, DE={2,3}, HL={4,5}, AF={7,6}.
- Reset values: state IDLE, o_req_ready=1, o_busy=0, o_wr_en=0, o_wr_sel=0, o_wr_data=0, o_done=0, o_result=0, latched op/pair/data=0, therefore read selects = {0,1}.
- FSM states: IDLE -> CALC -> WR_LO -> WR_HI -> IDLE.
- IDLE: if i_req_valid, latch op/pair/data on the clock edge and go to CALC; otherwise stay in IDLE.
- CALC: read selects come from the latched pair. Register result = {i_rd_hi,i_rd_lo}+1 (INC), -1 (DEC) or latched data (LOAD).
  - Arithmetic is modulo 2^16: 0xFFFF+1=0x0000, 0x0000-1=0xFFFF.
  - No flags are produced.
  - If pair=AF, result[3:0] is forced to 0.
- WR_LO: o_wr_en=1, o_wr_sel=lo index, o_wr_data=result[7:0].
- WR_HI: o_wr_en=1, o_wr_sel=hi index, o_wr_data=result[15:8], o_done=1. o_result updates on the clock edge ending WR_HI.
- Write outputs are combinational from state and the registered result. o_wr_en=0 in IDLE and CALC.
- Reserved op, or pair=AF with PAIR_AF_EN=0: sequence passes through CALC to IDLE with o_done pulsed in CALC, no writes, o_result unchanged.
- Latency: request accepted at edge T, low write in cycle T+2, high write and o_done in cycle T+3, o_req_ready high again in cycle T+4. Throughput is one request per 4 cycles.
- i_req_valid while busy is ignored (ready=0). Request fields may change after acceptance without effect.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. A low byte already written stays written; no high write and no o_done follow.
- Back-to-back requests on the same pair: the second CALC reads the values written by the first (the register file write has landed by then).

Test Plan:
- Reset, LOAD HL=0x1234 -> cycle T+2 write sel5 data0x34, T+3 write sel4 data0x12 with o_done=1, o_result=0x1234, ready at T+4.
- Register file BC=0x00FF, INC BC -> writes C=0x00, then B=0x01; o_result=0x0100.
- DEC DE from 0x0000 -> writes E=0xFF, D=0xFF; o_result=0xFFFF. INC DE from 0xFFFF -> 0x0000.
- LOAD AF=0xABCD (PAIR_AF_EN=1) -> F(6)=0xC0, A(7)=0xAB; o_result=0xABC0.
  - Reserved op -> no o_wr_en, o_done in cycle T+1, o_result unchanged.
- Back-to-back INC HL x2 from 0x10FF, valid held high -> second accepted at T+4; final HL=0x1101; ready low throughout busy.
- Assert i_rst during WR_LO of LOAD BC=0x5566 -> C=0x66 written, B unchanged, no o_done, outputs at reset values, ready=1 after release.
